// File: rtl/prold_loader.sv
// prold_loader -- program-load sequencer for the instruction fetch unit.
//
// Consumes a UART byte stream made of a 4-byte big-endian word count N and
// then N big-endian 32-bit instructions. Each instruction is presented to
// the fetch unit as a one-cycle prold_order strobe with its address and data.
// prold_mode stays high until the last write has retired.
//
// Optional feature macro: PROLD_LOADER_CHECKSUM_EN
//   When defined, one trailing byte follows the data. It must equal the XOR
//   of all 4N data bytes. On a mismatch err is set and done is suppressed.
//
// Ports:
//   i_clk          clock, all state on the rising edge
//   i_rstn         asynchronous active-low reset
//   i_start        one-cycle load request, honoured only in IDLE
//   i_rx_valid     byte available from the UART receiver
//   i_rx_data      received byte
//   o_rx_ready     byte consumed when i_rx_valid & o_rx_ready
//   o_prold_mode   fetch unit in load mode (prefetch halted)
//   o_prold_order  one-cycle write strobe for o_prold_pc / o_prold_data
//   o_prold_pc     byte address of the word being written
//   o_prold_data   instruction word being written
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse on error-free completion
//   o_err          sticky error flag, cleared by the next accepted start
module prold_loader #(
  parameter int LEN_WORD     = 32,
  parameter int BASE_PC      = 0,
  parameter int MAX_WORDS    = 16384,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_data,
  output logic                o_rx_ready,
  output logic                o_prold_mode,
  output logic                o_prold_order,
  output logic [LEN_WORD-1:0] o_prold_pc,
  output logic [LEN_WORD-1:0] o_prold_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int DCW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic                r_rx_ready;
  logic                r_mode;
  logic                r_order;
  logic [LEN_WORD-1:0] r_pc;
  logic [LEN_WORD-1:0] r_data;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_byte_cnt;
  logic [WCW-1:0]      r_word_cnt;
  logic [31:0]         r_len;
  logic [23:0]         r_shift;
  logic [DCW-1:0]      r_dcnt;
`ifdef PROLD_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  logic                w_accept;
  logic [31:0]         w_len_next;
  logic [31:0]         w_word_next;
  logic [WCW-1:0]      w_last;

  assign w_accept    = i_rx_valid & r_rx_ready;
  assign w_len_next  = {r_len[23:0], i_rx_data};
  assign w_word_next = {r_shift, i_rx_data};
  // Index of the final word; N has already been range-checked against MAX_WORDS.
  assign w_last      = WCW'(r_len - 32'd1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_mode     <= 1'b0;
      r_order    <= 1'b0;
      r_pc       <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      r_dcnt     <= '0;
`ifdef PROLD_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_order <= 1'b0;
      r_done  <= 1'b0;
      // Address advances in the cycle after each strobe, so the strobe
      // cycle always shows the address of the word being written.
      if (r_order) r_pc <= r_pc + LEN_WORD'(4);

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LEN;
            r_mode     <= 1'b1;
            r_busy     <= 1'b1;
            r_rx_ready <= 1'b1;
            r_pc       <= LEN_WORD'(BASE_PC);
            r_err      <= 1'b0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
`ifdef PROLD_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
          end
        end

        S_LEN: begin
          if (w_accept) begin
            r_len      <= w_len_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (w_len_next == '0) begin
                r_state    <= S_DRAIN;
                r_rx_ready <= 1'b0;
                r_dcnt     <= '0;
              end else if (w_len_next > 32'(MAX_WORDS)) begin
                r_state    <= S_IDLE;
                r_err      <= 1'b1;
                r_mode     <= 1'b0;
                r_busy     <= 1'b0;
                r_rx_ready <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_shift    <= w_word_next[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROLD_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ i_rx_data;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_order    <= 1'b1;
              r_data     <= LEN_WORD'(w_word_next);
              r_word_cnt <= r_word_cnt + WCW'(1);
              if (r_word_cnt == w_last) begin
`ifdef PROLD_LOADER_CHECKSUM_EN
                r_state    <= S_CSUM;
`else
                r_state    <= S_DRAIN;
                r_rx_ready <= 1'b0;
                r_dcnt     <= '0;
`endif
              end
            end
          end
        end

`ifdef PROLD_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            // The writes are already committed; a bad checksum only flags err.
            if (i_rx_data != r_csum) r_err <= 1'b1;
            r_state    <= S_DRAIN;
            r_rx_ready <= 1'b0;
            r_dcnt     <= '0;
          end
        end
`endif

        S_DRAIN: begin
          if (r_dcnt == DCW'(DRAIN_CYCLES)) begin
            r_state <= S_IDLE;
            r_done  <= ~r_err;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt + DCW'(1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_mode     <= 1'b0;
          r_busy     <= 1'b0;
          r_rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready    = r_rx_ready;
  assign o_prold_mode  = r_mode;
  assign o_prold_order = r_order;
  assign o_prold_pc    = r_pc;
  assign o_prold_data  = r_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_prold_loader.sv
// tb_prold_loader -- directed, table-driven bench for prold_loader.
// Each table record holds one load (length, words, byte gap) together with
// the expected write strobes, done pulse and error flag.
module tb_prold_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        o_rx_ready;
  logic        o_prold_mode;
  logic        o_prold_order;
  logic [31:0] o_prold_pc;
  logic [31:0] o_prold_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  prold_loader dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_rx_ready   (o_rx_ready),
    .o_prold_mode (o_prold_mode),
    .o_prold_order(o_prold_order),
    .o_prold_pc   (o_prold_pc),
    .o_prold_data (o_prold_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      len;
    logic [2:0][31:0] w;
    logic [3:0]       nw;
    logic [3:0]       gap;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int wait_cnt = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          mode_bad = 0;
`ifdef PROLD_LOADER_CHECKSUM_EN
  logic [7:0]  csum_flip = 8'h00;
`endif

  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records every write strobe and done pulse with its cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_prold_order) begin
        q_pc.push_back(o_prold_pc);
        q_data.push_back(o_prold_data);
        q_cyc.push_back(cyc);
      end
      if (o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (o_prold_mode !== o_busy) mode_bad = mode_bad + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    int   tries;
    tries = 0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (1) begin
      rdy = o_rx_ready;
      @(negedge clk);
      if (rdy) break;
      wait_cnt++;
      tries++;
      if (tries > 100) begin
        chk("accept_timeout", {63'd0, rdy}, 64'd1);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_state", {60'd0, o_prold_mode, o_busy, o_rx_ready, o_err}, 64'hE);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle", {63'd0, o_busy}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int         qb;
    int         db;
    int         mb;
    int         wb;
    int         last;
    logic [7:0] cs;
    qb = q_pc.size();
    db = done_cnt;
    mb = mode_bad;
    wb = wait_cnt;
    cs = 8'h00;
    do_start();
    for (int i = 0; i < 4; i++) send_byte(v.len[31-8*i -: 8], int'(v.gap));
    for (int k = 0; k < int'(v.nw); k++) begin
      for (int i = 0; i < 4; i++) begin
        cs = cs ^ v.w[k][31-8*i -: 8];
        send_byte(v.w[k][31-8*i -: 8], int'(v.gap));
      end
    end
`ifdef PROLD_LOADER_CHECKSUM_EN
    if (v.nw != 0) send_byte(cs ^ csum_flip, int'(v.gap));
`endif
    wait_idle();
    repeat (6) @(negedge clk);
    chk({nm, "_orders"}, 64'(q_pc.size() - qb), 64'(v.nw));
    for (int k = 0; k < int'(v.nw) && (qb + k) < q_pc.size(); k++) begin
      chk({nm, "_pc"}, 64'(q_pc[qb+k]), 64'(4 * k));
      chk({nm, "_data"}, 64'(q_data[qb+k]), 64'(v.w[k]));
    end
    chk({nm, "_done"}, 64'(done_cnt - db), 64'(v.exp_done));
    chk({nm, "_err"}, {63'd0, o_err}, {63'd0, v.exp_err});
    chk({nm, "_mode"}, 64'(mode_bad - mb), 64'd0);
    chk({nm, "_ready"}, 64'(wait_cnt - wb), 64'd0);
    last = q_pc.size() - 1;
`ifndef PROLD_LOADER_CHECKSUM_EN
    if (v.gap == 0 && v.nw >= 2 && q_cyc.size() >= qb + 2)
      chk({nm, "_spacing"}, 64'(q_cyc[qb+1] - q_cyc[qb]), 64'd4);
    if (v.exp_done && v.nw != 0 && last >= qb)
      chk({nm, "_drain"}, 64'(done_cyc - q_cyc[last]), 64'd4);
`endif
  endtask

  initial begin
    int   qb;
    vec_t v;

    vecs[0] = '{len: 32'd2, w: {32'h0, 32'h12345678, 32'hDEADBEEF}, nw: 4'd2, gap: 4'd0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{len: 32'd2, w: {32'h0, 32'h12345678, 32'hDEADBEEF}, nw: 4'd2, gap: 4'd5, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{len: 32'd0, w: {32'h0, 32'h0, 32'h0}, nw: 4'd0, gap: 4'd0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{len: 32'd16385, w: {32'h0, 32'h0, 32'h0}, nw: 4'd0, gap: 4'd0, exp_done: 1'b0, exp_err: 1'b1};
    vecs[4] = '{len: 32'd1, w: {32'h0, 32'h0, 32'hCAFEF00D}, nw: 4'd1, gap: 4'd0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[5] = '{len: 32'd3, w: {32'hFFFFFFFF, 32'h00000000, 32'hA5A50001}, nw: 4'd3, gap: 4'd1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[6] = '{len: 32'd1, w: {32'h0, 32'h0, 32'h80000001}, nw: 4'd1, gap: 4'd3, exp_done: 1'b1, exp_err: 1'b0};

    #1;
    chk("rst_ctrl", {58'd0, o_busy, o_prold_mode, o_rx_ready, o_prold_order, o_done, o_err}, 64'd0);
    chk("rst_pc", 64'(o_prold_pc), 64'd0);
    chk("rst_data", 64'(o_prold_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a word: everything clears at once, no writes.
    qb = q_pc.size();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_ctrl", {58'd0, o_busy, o_prold_mode, o_rx_ready, o_prold_order, o_done, o_err}, 64'd0);
    chk("midrst_pc", 64'(o_prold_pc), 64'd0);
    chk("midrst_data", 64'(o_prold_data), 64'd0);
    chk("midrst_orders", 64'(q_pc.size() - qb), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    v = '{len: 32'd1, w: {32'h0, 32'h0, 32'h11223344}, nw: 4'd1, gap: 4'd0, exp_done: 1'b1, exp_err: 1'b0};
    run_vec(v, "after_rst");

`ifdef PROLD_LOADER_CHECKSUM_EN
    v = '{len: 32'd1, w: {32'h0, 32'h0, 32'h01020408}, nw: 4'd1, gap: 4'd0, exp_done: 1'b1, exp_err: 1'b0};
    csum_flip = 8'h00;
    run_vec(v, "csum_ok");
    v.exp_done = 1'b0;
    v.exp_err  = 1'b1;
    csum_flip  = 8'h01;
    run_vec(v, "csum_bad");
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prold_loader.md
Name: prold_loader

Overview:
- Program-load (prold) sequencer for the instruction fetch unit.
- Receives a byte stream from the UART receiver: a 4-byte big-endian word count N, then N big-endian 32-bit instructions.
- Drives the fetch unit's prold fields (mode, order, pc, data) so each instruction is written to consecutive instruction-memory words.
- Holds prold_mode high until the last write has retired, so prefetch cannot race the writes.

Parameters:
- LEN_WORD, 32, width of pc and data words.
- BASE_PC, 0, byte address of the first loaded instruction; must be 4-aligned.
- MAX_WORDS, 16384, largest accepted N; larger N is an error.
- DRAIN_CYCLES, 3, cycles prold_mode stays high after the last order pulse.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- rx_valid  in  1  byte available from UART receiver.
- rx_data  in  8  received byte.
- rx_ready  out  1  byte consumed this cycle when rx_valid & rx_ready.
- prold_mode  out  1  fetch unit in load mode; fetch stops prefetching.
- prold_order  out  1  one-cycle write strobe for prold_pc / prold_data.
- prold_pc  out  LEN_WORD  byte address of the word being written.
- prold_data  out  LEN_WORD  instruction word being written.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes without error.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset: all outputs are 0, prold_pc is 0, and the FSM is in IDLE. Reset is asynchronous and may arrive mid-load; it abandons the load with no further order pulses.
- All outputs are registered.
- FSM states: IDLE, LEN, DATA, DRAIN.
- IDLE:
  - On start, go to LEN, set prold_mode=1, load prold_pc=BASE_PC, clear err, byte_cnt=0, word_cnt=0.
  - start in any other state is ignored.
- LEN:
  - rx_ready=1.
  - Each accepted byte shifts into a length register MSB-first.
  - After the 4th byte:
    - N==0: go to DRAIN.
    - N>MAX_WORDS: set err, drop prold_mode, go to IDLE; no done pulse.
    - Otherwise go to DATA.
- DATA:
  - rx_ready=1; bytes assemble MSB-first into a shift register.
  - The cycle after the 4th byte of a word is accepted:
    - prold_order=1 for exactly one cycle.
    - prold_data holds the assembled word.
    - prold_pc holds the word's address.
  - On the cycle after each order pulse, prold_pc increments by 4, wrapping modulo 2^LEN_WORD.
  - The 4th byte of a word and the 1st byte of the next word may be accepted on back-to-back cycles. Peak throughput is 1 byte per cycle, so order pulses are at least 4 cycles apart.
  - After word N is assembled, go to DRAIN. rx_ready drops the cycle after the final byte.
- DRAIN:
  - rx_ready=0; prold_mode stays 1.
  - The last order pulse occurs in the first DRAIN cycle.
  - A counter runs DRAIN_CYCLES cycles after that pulse, covering the fetch unit's one-cycle write register plus margin.
  - At the end: done=1 for one cycle, prold_mode=0, go to IDLE.
- rx_valid=0 stalls LEN and DATA indefinitely. There is no timeout. Partially assembled bytes are kept.
- Bytes presented while rx_ready=0 are not consumed; upstream holds them.
- Counter widths: byte_cnt is 2 bits. word_cnt is clog2(MAX_WORDS+1) bits and compared against N.

Optional Feature:
- Macro: PROLD_LOADER_CHECKSUM_EN.
- When defined:
  - A CSUM state sits between DATA and DRAIN.
  - CSUM accepts one trailing byte, which must equal the XOR of all 4N data bytes.
  - Mismatch: set err, skip done, drop prold_mode after DRAIN.
  - Match: proceed to DRAIN normally.
  - The writes have already happened in either case.
- When undefined: no trailing byte is consumed, and DATA goes directly to DRAIN.

Test Plan:
- Basic load: start; bytes 00 00 00 02, DE AD BE EF, 12 34 56 78 at 1 byte/cycle → order pulses with (pc=0x0, data=0xDEADBEEF) and (pc=0x4, data=0x12345678). Pulses are exactly 4 cycles apart. done pulses DRAIN_CYCLES+1 cycles after the second order. prold_mode is high from the cycle after start until done.
- Stalled stream: same data with rx_valid low for 5 cycles between every byte → identical pc/data pairs; no extra order pulses; rx_ready stays high in DATA.
- Zero length: N=00000000 → no order pulse, done after DRAIN, err=0.
- Oversize: N=MAX_WORDS+1 → err=1, prold_mode drops, no order, no done. A following start with N=1 clears err and writes a word at BASE_PC.
- Reset mid-load: assert rstn=0 after 2 of 4 data bytes → all outputs 0 immediately. After release, a fresh start loads from BASE_PC again.
- Checksum (with PROLD_LOADER_CHECKSUM_EN): N=1, data 01 02 04 08, trailing byte 0x0F → done. Trailing byte 0x0E → err=1, no done.
